// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: per accepted request, drives N single-cycle toggle pulses spaced by G idle cycles.
// Define TOGGLE_PULSE_ABORT_EN to add the abort input and aborted completion flag.
module toggle_pulse_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [GAP_W-1:0] req_gap,
`ifdef TOGGLE_PULSE_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             t_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             t_out_q, t_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_ready_q, req_ready_d;
    logic             accept_s;
    logic             abort_hit_s;

    assign accept_s = req_valid && req_ready_q;

`ifdef TOGGLE_PULSE_ABORT_EN
    logic aborted_q, aborted_d;

    // An abort during the final pulse is a normal completion, so it is not counted as a hit.
    assign abort_hit_s = abort && busy_q &&
                         !((state_q == S_PULSE) && (rem_q == CNT_W'(1)));
    assign aborted_d   = abort_hit_s;
    assign aborted     = aborted_q;
`else
    assign abort_hit_s = 1'b0;
`endif

    // Next-state, counter and output-decode logic.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    gap_len_d = req_gap;
                    rem_d     = req_count;
                    if (req_count == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else if (abort_hit_s) begin
                    state_d = S_DONE;
                end else if (gap_len_q == {GAP_W{1'b0}}) begin
                    state_d = S_PULSE;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_len_q;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (abort_hit_s) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_PULSE;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        t_out_d     = (state_d == S_PULSE);
        busy_d      = (state_d == S_PULSE) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
        req_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= {CNT_W{1'b0}};
            gap_len_q   <= {GAP_W{1'b0}};
            gap_cnt_q   <= {GAP_W{1'b0}};
            t_out_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            t_out_q     <= t_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef TOGGLE_PULSE_ABORT_EN
    // One-cycle aborted flag, co-timed with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end
`endif

    assign t_out     = t_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: directed and random requests against a schedule-queue model.
module tb_toggle_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_count;
    logic [7:0] req_gap;
    logic       t_out;
    logic       busy;
    logic       done;
`ifdef TOGGLE_PULSE_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    toggle_pulse_gen #(.CNT_W(8), .GAP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_gap   (req_gap),
`ifdef TOGGLE_PULSE_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .t_out     (t_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream T-type register fed by t_out.
    logic tq;
    initial tq = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) tq <= 1'b0;
        else if (t_out) tq <= ~tq;
    end

    // Expected outputs for one cycle.
    typedef struct packed {
        logic t;
        logic bz;
        logic dn;
        logic rdy;
        logic ab;
    } exp_t;

    localparam exp_t E_PULSE = '{t: 1'b1, bz: 1'b1, dn: 1'b0, rdy: 1'b0, ab: 1'b0};
    localparam exp_t E_GAP   = '{t: 1'b0, bz: 1'b1, dn: 1'b0, rdy: 1'b0, ab: 1'b0};
    localparam exp_t E_DONE  = '{t: 1'b0, bz: 1'b0, dn: 1'b1, rdy: 1'b1, ab: 1'b0};
    localparam exp_t E_DONEA = '{t: 1'b0, bz: 1'b0, dn: 1'b1, rdy: 1'b1, ab: 1'b1};
    localparam exp_t E_IDLE  = '{t: 1'b0, bz: 1'b0, dn: 1'b0, rdy: 1'b1, ab: 1'b0};
    localparam exp_t E_RST   = '{t: 1'b0, bz: 1'b0, dn: 1'b0, rdy: 1'b0, ab: 1'b0};

    exp_t exp_q[$];
    exp_t cur;
    int   n_assert;
    int   n_fail;
    int   model_pulses;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an accepted request expands into its full cycle-by-cycle schedule.
    task automatic model_edge();
        int n;
        int g;
        if (!rst_n) begin
            exp_q.delete();
            cur = E_RST;
        end else begin
`ifdef TOGGLE_PULSE_ABORT_EN
            if (abort && cur.bz && exp_q.size() > 0 && !exp_q[0].dn) begin
                exp_q.delete();
                exp_q.push_back(E_DONEA);
            end
`endif
            if (req_valid && cur.rdy) begin
                n = int'(req_count);
                g = int'(req_gap);
                for (int i = 1; i <= n; i++) begin
                    exp_q.push_back(E_PULSE);
                    if (i < n) for (int j = 0; j < g; j++) exp_q.push_back(E_GAP);
                end
                exp_q.push_back(E_DONE);
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = E_IDLE;
        end
        if (cur.t) model_pulses++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("t_out", t_out, cur.t);
        chk("busy", busy, cur.bz);
        chk("done", done, cur.dn);
        chk("req_ready", req_ready, cur.rdy);
`ifdef TOGGLE_PULSE_ABORT_EN
        chk("aborted", aborted, cur.ab);
`endif
        @(negedge clk);
    endtask

    task automatic run_idle();
        int guard;
        guard = 0;
        while (!(cur.rdy && exp_q.size() == 0) && guard < 3000) begin
            step();
            guard++;
        end
        n_assert++;
        assert (guard < 3000) else begin
            n_fail++;
            $error("FAIL idle_timeout: observed %0d cycles expected < 3000", guard);
        end
    endtask

    task automatic send(input int n, input int g);
        run_idle();
        req_valid = 1'b1;
        req_count = 8'(n);
        req_gap   = 8'(g);
        step();
        req_valid = 1'b0;
        req_count = 8'($urandom);
        req_gap   = 8'($urandom);
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        model_pulses = 0;
        cur          = E_RST;
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_count    = 8'd3;
        req_gap      = 8'd1;
`ifdef TOGGLE_PULSE_ABORT_EN
        abort        = 1'b0;
`endif

        // Reset held for three edges with a pending request.
        repeat (3) step();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        step();

        // N=4, G=0: back-to-back pulses; the T stage returns to 0.
        send(4, 0);
        run_idle();
        chk("tq_even", tq, 1'b0);

        // N=3, G=2.
        send(3, 2);
        run_idle();

        // N=0 then a request accepted during its done cycle.
        send(0, 5);
        req_valid = 1'b1;
        req_count = 8'd1;
        req_gap   = 8'd0;
        step();
        req_valid = 1'b0;
        run_idle();

        // Reset after the second pulse of N=5, G=1, then a fresh request.
        model_pulses = 0;
        send(5, 1);
        while (model_pulses < 2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(2, 1);
        run_idle();

        // Counter-width boundaries.
        send(255, 0);
        send(2, 255);
        send(1, 255);
        run_idle();

`ifdef TOGGLE_PULSE_ABORT_EN
        // Abort during the second gap of N=10, G=3.
        model_pulses = 0;
        send(10, 3);
        while (!(model_pulses == 2 && cur.bz && !cur.t)) step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_idle();
`endif

        // Randomized traffic including resets and ignored valids while busy.
        for (int c = 0; c < 1500; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_count = 8'($urandom_range(0, 5));
            req_gap   = 8'($urandom_range(0, 3));
`ifdef TOGGLE_PULSE_ABORT_EN
            abort     = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
`ifdef TOGGLE_PULSE_ABORT_EN
        abort     = 1'b0;
`endif
        run_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
- Upstream driver for the T-type toggle register stage.
- Accepts a request through a valid/ready handshake, carrying a pulse count N and an inter-pulse gap G.
- Emits exactly N single-cycle toggle pulses on t_out, separated by G idle cycles, then signals completion.
- t_out connects directly to the toggle register's t input, so the register toggles exactly N times per request.

Parameters:
- CNT_W, 8, width of the pulse-count field; N ranges 0 to 2^CNT_W-1.
- GAP_W, 8, width of the gap field; G ranges 0 to 2^GAP_W-1 idle cycles between pulses.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; registered.
- req_count  input  CNT_W  number of pulses N; sampled on acceptance.
- req_gap  input  GAP_W  idle cycles G between pulses; sampled on acceptance.
- t_out  output  1  toggle pulse to the T stage; registered.
- busy  output  1  request in progress; registered.
- done  output  1  one-cycle completion strobe; registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n). All state changes occur only on the clk rising edge.
- Reset values, in any cycle where rst_n is sampled low:
  - State returns to IDLE and both internal counters clear.
  - t_out=0, busy=0, done=0, req_ready=0.
  - req_ready rises to 1 in the first cycle after rst_n is sampled high.
- States:
  - IDLE: req_ready=1, busy=0, t_out=0.
  - PULSE: t_out=1, busy=1, req_ready=0.
  - GAP: t_out=0, busy=1, req_ready=0.
  - DONE: done=1, busy=0, req_ready=1; lasts one cycle.
- Acceptance:
  - A request is accepted at a rising edge where req_valid=1 and req_ready=1.
  - req_count and req_gap are latched into internal registers at that edge.
  - Input changes after acceptance have no effect on the request in progress.
- Transitions (acceptance at edge k):
  - N=0: DONE in cycle k+1. No pulse is issued.
  - N>=1: PULSE in cycle k+1. Pulse i (1..N) is high in cycle k+1+(i-1)*(G+1).
  - After each non-final pulse: GAP for exactly G cycles, then PULSE.
  - G=0: pulses are back-to-back and t_out stays high for N consecutive cycles.
  - After the final pulse (cycle L): DONE in cycle L+1, then IDLE.
- Back-to-back requests: req_ready=1 during DONE, so a request accepted at the end of DONE produces its first pulse in the very next cycle. There is no dead cycle between requests.
- req_valid while req_ready=0 is ignored; no request is queued.
- Counter width rules:
  - The remaining-pulse counter is CNT_W bits and decrements once per PULSE cycle.
  - The gap counter is GAP_W bits and counts G down to 0.
  - Neither counter may wrap: maximum N (all ones) yields exactly 2^CNT_W-1 pulses, and maximum G yields exactly 2^GAP_W-1 gap cycles.
- Reset mid-operation: applies the reset values on the next edge. Remaining pulses are discarded and no done is issued for the aborted request.
- Invariants: t_out and done are never high in the same cycle; busy=1 exactly from the first PULSE through the final PULSE or GAP cycle.

Optional Feature:
- Macro: TOGGLE_PULSE_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort sampled high while busy=1: no further pulses are issued, even if the current cycle is GAP.
  - The next cycle is DONE with done=1 and aborted=1; aborted lasts one cycle, co-timed with done.
  - abort is ignored in IDLE and DONE.
  - If abort is sampled on the same edge that would start the final pulse's successor, completion is normal and aborted=0.
- Not defined: the abort and aborted ports do not exist, and every request runs to completion.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with req_valid=1 -> t_out=0, busy=0, done=0, req_ready=0 throughout; req_ready=1 in the first cycle after release.
- N=3, G=2, accepted at edge k -> t_out high in cycles k+1, k+4 and k+7 only; done=1 in cycle k+8; busy high from k+1 to k+7.
- N=4, G=0 -> t_out high for 4 consecutive cycles; done in the following cycle. The downstream T stage, starting at q=0, ends at q=0.
- N=0, any G -> no t_out pulse; done=1 in cycle k+1. Second request N=1, G=0 accepted during that done cycle -> its pulse occurs in cycle k+2.
- N=5, G=1, rst_n=0 sampled after the 2nd pulse -> no further pulses, no done; idle outputs restored; a new request completes normally.
- With TOGGLE_PULSE_ABORT_EN: N=10, G=3, abort=1 during the 2nd GAP -> exactly 2 pulses; next cycle done=1 and aborted=1; req_ready=1.
